// File: rtl/mpram_pkg.sv
// rtl/mpram_pkg.sv - shared constants, write-request type and round-robin helper
//
// Purpose : default RAM geometry, the write-request record used by writers of
//           the multi-port RAM, and a modulo helper for round-robin indexing.
// Ports   : none (package).
package mpram_pkg;

  localparam int MPRAM_DEPTH       = 2048;
  localparam int MPRAM_WIDTH       = 32;
  localparam int MPRAM_INDEX_WIDTH = $clog2(MPRAM_DEPTH);

  // Sized by the default geometry; blocks built with other geometries carry
  // their own addr/data vectors.
  typedef struct packed {
    logic [MPRAM_INDEX_WIDTH-1:0] addr;
    logic [MPRAM_WIDTH-1:0]       data;
    logic                         valid;
  } mpram_wr_req_t;

  // Wraps an index that has overrun the ring by at most one lap.
  function automatic int rr_wrap(input int idx, input int n);
    return (idx >= n) ? (idx - n) : idx;
  endfunction

endpackage

// File: rtl/mpram_rr_picker.sv
// rtl/mpram_rr_picker.sv - round-robin first-set picker
//
// Purpose : finds the first set bit of a candidate mask at or after a start
//           pointer, wrapping modulo P_N.
// Ports   : mask      - candidate bits
//           start     - index where the search begins
//           grant_oh  - one-hot of the chosen candidate (0 when none)
//           grant_idx - binary index of the chosen candidate
//           found     - a candidate was chosen
module mpram_rr_picker
  import mpram_pkg::*;
#(
  parameter  int P_N   = 4,
  localparam int LP_PW = $clog2(P_N)
) (
  input  logic [P_N-1:0]   mask,
  input  logic [LP_PW-1:0] start,
  output logic [P_N-1:0]   grant_oh,
  output logic [LP_PW-1:0] grant_idx,
  output logic             found
);

  always_comb begin
    int k;
    grant_oh  = '0;
    grant_idx = '0;
    found     = 1'b0;
    k         = 0;
    for (int i = 0; i < P_N; i++) begin
      k = rr_wrap(int'(start) + i, P_N);
      if (!found && mask[k]) begin
        grant_oh[k] = 1'b1;
        grant_idx   = LP_PW'(k);
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mpram_wr_arbiter.sv
// rtl/mpram_wr_arbiter.sv - dual-write-port round-robin arbiter for a multi-port RAM
//
// Purpose : grants up to two requesters per cycle (never to the same address)
//           and registers them onto RAM write ports A and B.
// Ports   : clk_i, rst_i (async, active-high)
//           req_valid_i/req_addr_i/req_data_i - per-requester write requests
//           req_ready_o                        - grant, transfer on valid&ready
//           wra_*_o / wrb_*_o                  - registered RAM write ports
//           stall_cnt_o                        - cycles with an ungranted valid
// Options : define MPRAM_WR_ARB_STATS_EN to build the saturating stall counter;
//           otherwise stall_cnt_o is tied to 0.
module mpram_wr_arbiter
  import mpram_pkg::*;
#(
  parameter  int P_MEM_DEPTH    = MPRAM_DEPTH,
  parameter  int P_MEM_WIDTH    = MPRAM_WIDTH,
  parameter  int P_NUM_REQ      = 4,
  localparam int LP_INDEX_WIDTH = $clog2(P_MEM_DEPTH)
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic [P_NUM_REQ-1:0]                      req_valid_i,
  input  logic [P_NUM_REQ-1:0][LP_INDEX_WIDTH-1:0]  req_addr_i,
  input  logic [P_NUM_REQ-1:0][P_MEM_WIDTH-1:0]     req_data_i,
  output logic [P_NUM_REQ-1:0]                      req_ready_o,
  output logic [LP_INDEX_WIDTH-1:0]                 wra_addr_o,
  output logic [P_MEM_WIDTH-1:0]                    wra_data_o,
  output logic                                      wra_valid_o,
  output logic [LP_INDEX_WIDTH-1:0]                 wrb_addr_o,
  output logic [P_MEM_WIDTH-1:0]                    wrb_data_o,
  output logic                                      wrb_valid_o,
  output logic [31:0]                               stall_cnt_o
);

  localparam int LP_PW = $clog2(P_NUM_REQ);

  logic [LP_PW-1:0]     rr_ptr;
  logic [LP_PW-1:0]     rr_ptr_nxt;
  logic [LP_PW-1:0]     g0_idx, g1_idx, g1_start, last_idx;
  logic [P_NUM_REQ-1:0] g0_oh, g1_oh, same_addr, g1_mask, grant_oh;
  logic                 g0_found, g1_found;

  mpram_rr_picker #(.P_N(P_NUM_REQ)) u_pick_g0 (
    .mask      (req_valid_i),
    .start     (rr_ptr),
    .grant_oh  (g0_oh),
    .grant_idx (g0_idx),
    .found     (g0_found)
  );

  // Anyone aiming at G0's address must wait, so the two ports never collide.
  always_comb begin
    same_addr = '0;
    for (int i = 0; i < P_NUM_REQ; i++) begin
      same_addr[i] = (req_addr_i[i] == req_addr_i[g0_idx]);
    end
  end

  assign g1_mask  = req_valid_i & ~g0_oh & ~same_addr;
  // Indices between rr_ptr and G0 are known idle, so resuming after G0
  // preserves the round-robin order.
  assign g1_start = LP_PW'(rr_wrap(int'(g0_idx) + 1, P_NUM_REQ));

  mpram_rr_picker #(.P_N(P_NUM_REQ)) u_pick_g1 (
    .mask      (g1_mask),
    .start     (g1_start),
    .grant_oh  (g1_oh),
    .grant_idx (g1_idx),
    .found     (g1_found)
  );

  assign grant_oh    = g0_oh | g1_oh;
  assign req_ready_o = rst_i ? '0 : grant_oh;

  assign last_idx   = g1_found ? g1_idx : g0_idx;
  assign rr_ptr_nxt = LP_PW'(rr_wrap(int'(last_idx) + 1, P_NUM_REQ));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr      <= '0;
      wra_valid_o <= 1'b0;
      wra_addr_o  <= '0;
      wra_data_o  <= '0;
      wrb_valid_o <= 1'b0;
      wrb_addr_o  <= '0;
      wrb_data_o  <= '0;
    end else begin
      if (g0_found) begin
        rr_ptr <= rr_ptr_nxt;
      end
      wra_valid_o <= g0_found;
      if (g0_found) begin
        wra_addr_o <= req_addr_i[g0_idx];
        wra_data_o <= req_data_i[g0_idx];
      end
      wrb_valid_o <= g1_found;
      if (g1_found) begin
        wrb_addr_o <= req_addr_i[g1_idx];
        wrb_data_o <= req_data_i[g1_idx];
      end
    end
  end

`ifdef MPRAM_WR_ARB_STATS_EN
  logic [31:0] stall_cnt;
  logic        stall;

  assign stall = |(req_valid_i & ~grant_oh);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_mpram_wr_arbiter.sv
// tb/tb_mpram_wr_arbiter.sv - directed table-driven bench for mpram_wr_arbiter
module tb_mpram_wr_arbiter;

  logic             clk;
  logic             rst;
  logic [3:0]       req_valid;
  logic [3:0][10:0] req_addr;
  logic [3:0][31:0] req_data;
  logic [3:0]       req_ready;
  logic [10:0]      wra_addr, wrb_addr;
  logic [31:0]      wra_data, wrb_data;
  logic             wra_valid, wrb_valid;
  logic [31:0]      stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  mpram_wr_arbiter #(.P_MEM_DEPTH(2048), .P_MEM_WIDTH(32), .P_NUM_REQ(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_addr_i  (req_addr),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .wra_addr_o  (wra_addr),
    .wra_data_o  (wra_data),
    .wra_valid_o (wra_valid),
    .wrb_addr_o  (wrb_addr),
    .wrb_data_o  (wrb_data),
    .wrb_valid_o (wrb_valid),
    .stall_cnt_o (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]       valid;
    logic [3:0][10:0] addr;
    logic [3:0][31:0] data;
    logic [3:0]       exp_ready;
    logic [1:0]       exp_ptr;
    logic             a_v;
    logic [10:0]      a_addr;
    logic [31:0]      a_data;
    logic             b_v;
    logic [10:0]      b_addr;
    logic [31:0]      b_data;
  } vec_t;

  vec_t vecs[8];
  int   cnt[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    // Rows are applied back to back from reset; each expectation follows the
    // round-robin pointer left by the previous row.
    vecs[0] = '{4'b0101, {11'h0, 11'h020, 11'h0, 11'h010},
                {32'h0, 32'h5A5A5A5A, 32'h0, 32'hA5A5A5A5},
                4'b0101, 2'd3, 1'b1, 11'h010, 32'hA5A5A5A5, 1'b1, 11'h020, 32'h5A5A5A5A};
    vecs[1] = '{4'b0010, {11'h0, 11'h0, 11'h033, 11'h0},
                {32'h0, 32'h0, 32'h11111111, 32'h0},
                4'b0010, 2'd2, 1'b1, 11'h033, 32'h11111111, 1'b0, 11'h020, 32'h5A5A5A5A};
    vecs[2] = '{4'b0000, {11'h0, 11'h0, 11'h0, 11'h0},
                {32'h0, 32'h0, 32'h0, 32'h0},
                4'b0000, 2'd2, 1'b0, 11'h033, 32'h11111111, 1'b0, 11'h020, 32'h5A5A5A5A};
    vecs[3] = '{4'b1111, {11'h103, 11'h102, 11'h101, 11'h100},
                {32'hD3, 32'hD2, 32'hD1, 32'hD0},
                4'b1100, 2'd0, 1'b1, 11'h102, 32'hD2, 1'b1, 11'h103, 32'hD3};
    vecs[4] = '{4'b1010, {11'h100, 11'h0, 11'h100, 11'h0},
                {32'hB3, 32'h0, 32'hB1, 32'h0},
                4'b0010, 2'd2, 1'b1, 11'h100, 32'hB1, 1'b0, 11'h103, 32'hD3};
    vecs[5] = '{4'b1000, {11'h100, 11'h0, 11'h0, 11'h0},
                {32'hB3, 32'h0, 32'h0, 32'h0},
                4'b1000, 2'd0, 1'b1, 11'h100, 32'hB3, 1'b0, 11'h103, 32'hD3};
    vecs[6] = '{4'b0111, {11'h0, 11'h201, 11'h200, 11'h200},
                {32'h0, 32'hE2, 32'hE1, 32'hE0},
                4'b0101, 2'd3, 1'b1, 11'h200, 32'hE0, 1'b1, 11'h201, 32'hE2};
    vecs[7] = '{4'b1001, {11'h7FE, 11'h0, 11'h0, 11'h7FF},
                {32'hF3, 32'h0, 32'h0, 32'hF0},
                4'b1001, 2'd1, 1'b1, 11'h7FE, 32'hF3, 1'b1, 11'h7FF, 32'hF0};

    rst       = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;

    // Ready must stay low while reset is held, even with requests present.
    #2;
    req_valid = 4'b1111;
    #1;
    chk("reset.ready", 64'(req_ready), 64'h0);
    req_valid = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Idle after reset.
    repeat (10) @(posedge clk);
    #1;
    chk("idle.wra_valid", 64'(wra_valid), 64'h0);
    chk("idle.wrb_valid", 64'(wrb_valid), 64'h0);
    chk("idle.wra_addr",  64'(wra_addr),  64'h0);
    chk("idle.wra_data",  64'(wra_data),  64'h0);
    chk("idle.wrb_addr",  64'(wrb_addr),  64'h0);
    chk("idle.wrb_data",  64'(wrb_data),  64'h0);
    chk("idle.ready",     64'(req_ready), 64'h0);
    chk("idle.rr_ptr",    64'(dut.rr_ptr), 64'h0);
    chk("idle.stall_cnt", 64'(stall_cnt), 64'h0);

    for (int i = 0; i < 8; i++) begin
      req_valid = vecs[i].valid;
      req_addr  = vecs[i].addr;
      req_data  = vecs[i].data;
      @(negedge clk);
      chk($sformatf("v%0d.ready", i), 64'(req_ready), 64'(vecs[i].exp_ready));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.rr_ptr", i),    64'(dut.rr_ptr), 64'(vecs[i].exp_ptr));
      chk($sformatf("v%0d.wra_valid", i), 64'(wra_valid),  64'(vecs[i].a_v));
      chk($sformatf("v%0d.wra_addr", i),  64'(wra_addr),   64'(vecs[i].a_addr));
      chk($sformatf("v%0d.wra_data", i),  64'(wra_data),   64'(vecs[i].a_data));
      chk($sformatf("v%0d.wrb_valid", i), 64'(wrb_valid),  64'(vecs[i].b_v));
      chk($sformatf("v%0d.wrb_addr", i),  64'(wrb_addr),   64'(vecs[i].b_addr));
      chk($sformatf("v%0d.wrb_data", i),  64'(wrb_data),   64'(vecs[i].b_data));
    end
    req_valid = '0;

    // Reset lands while a write to 0x7FF sits in the output register.
    req_valid   = 4'b0001;
    req_addr[0] = 11'h7FF;
    req_data[0] = 32'hCAFEF00D;
    @(negedge clk);
    chk("midrst.ready", 64'(req_ready), 64'h1);
    @(posedge clk);
    #1;
    req_valid = '0;
    chk("midrst.pre_valid", 64'(wra_valid), 64'h1);
    chk("midrst.pre_addr",  64'(wra_addr),  64'h7FF);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst.async_valid", 64'(wra_valid),   64'h0);
    chk("midrst.async_addr",  64'(wra_addr),    64'h0);
    chk("midrst.async_ptr",   64'(dut.rr_ptr),  64'h0);
    @(posedge clk);
    #1;
    chk("midrst.edge_wra_valid", 64'(wra_valid), 64'h0);
    chk("midrst.edge_wrb_valid", 64'(wrb_valid), 64'h0);
    @(negedge clk);
    rst         = 1'b0;
    req_valid   = 4'b0100;
    req_addr[2] = 11'h055;
    req_data[2] = 32'h12345678;
    #1;
    chk("postrst.ready", 64'(req_ready), 64'h4);
    @(posedge clk);
    #1;
    req_valid = '0;
    chk("postrst.wra_valid", 64'(wra_valid), 64'h1);
    chk("postrst.wra_addr",  64'(wra_addr),  64'h055);
    chk("postrst.wra_data",  64'(wra_data),  64'h12345678);

    // Fairness with all four requesters active on distinct addresses.
    rst = 1'b1;
    #2;
    rst = 1'b0;
    for (int j = 0; j < 4; j++) begin
      cnt[j]      = 0;
      req_addr[j] = 11'(11'h300 + j);
      req_data[j] = 32'(32'hC0 + j);
    end
    req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk($sformatf("fair%0d.ready", c), 64'(req_ready), (c % 2 == 0) ? 64'h3 : 64'hC);
      for (int j = 0; j < 4; j++) if (req_ready[j]) cnt[j]++;
      @(posedge clk);
      #1;
      chk($sformatf("fair%0d.wra_addr", c), 64'(wra_addr), (c % 2 == 0) ? 64'h300 : 64'h302);
      chk($sformatf("fair%0d.wrb_addr", c), 64'(wrb_addr), (c % 2 == 0) ? 64'h301 : 64'h303);
    end
    req_valid = '0;
    for (int j = 0; j < 4; j++) chk($sformatf("fair.count%0d", j), 64'(cnt[j]), 64'd4);

    // Stall statistic: three requesters, at most two grants, five cycles.
    rst = 1'b1;
    #2;
    rst = 1'b0;
    req_valid = 4'b0111;
    repeat (5) @(posedge clk);
    #1;
    req_valid = '0;
    @(posedge clk);
    #1;
`ifdef MPRAM_WR_ARB_STATS_EN
    chk("stats.stall_cnt", 64'(stall_cnt), 64'd5);
`else
    chk("stats.stall_cnt", 64'(stall_cnt), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mpram_wr_arbiter.md
MPRAM_WR_ARBITER -- requirements
Module: mpram_wr_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
- P_MEM_DEPTH, 2048, RAM depth (power of 2).
- P_MEM_WIDTH, 32, data width (8/16/32).
- P_NUM_REQ, 4, number of write requesters (2..8).
- LP_INDEX_WIDTH (localparam) = $clog2(P_MEM_DEPTH).

REQ-002 Ports SHALL be, one per line:
- clk_i  in  1  single clock.
- rst_i  in  1  reset, asynchronous, active-high.
- req_valid_i  in  P_NUM_REQ  per-requester write request.
- req_addr_i  in  P_NUM_REQ x LP_INDEX_WIDTH  per-requester address.
- req_data_i  in  P_NUM_REQ x P_MEM_WIDTH  per-requester data.
- req_ready_o  out  P_NUM_REQ  grant; the transfer occurs on valid&ready.
- wra_addr_o / wra_data_o / wra_valid_o  out  LP_INDEX_WIDTH / P_MEM_WIDTH / 1  RAM write port A.
- wrb_addr_o / wrb_data_o / wrb_valid_o  out  LP_INDEX_WIDTH / P_MEM_WIDTH / 1  RAM write port B.
- stall_cnt_o  out  32  stall statistic (see REQ-015).

Function
REQ-003 Each cycle the arbiter SHALL grant at most two requesters, using round-robin order starting at pointer rr_ptr.
- First grant (G0): the first valid index at or after rr_ptr, wrapping modulo P_NUM_REQ.
- Second grant (G1): the next valid index after G0 in the same order, excluding any requester whose req_addr_i equals G0's address.

REQ-004 When G0 and G1 target the same address, the later requester SHALL NOT be granted that cycle; it stays pending, and the next candidate in order is considered for G1.

REQ-005 req_ready_o SHALL be combinational from req_valid_i, req_addr_i and rr_ptr, and asserted only for G0/G1; ready SHALL never be asserted without the matching valid.

REQ-006 G0 SHALL be registered onto port A and G1 onto port B at the next clk_i edge.
- Latency is exactly 1 cycle from handshake to wr*_valid_o.
- No grant: the corresponding wr*_valid_o = 0, and addr/data hold their previous values.

REQ-007 Within one output cycle, wra_addr_o != wrb_addr_o SHALL hold whenever both valids are 1.

REQ-008 rr_ptr SHALL advance to (last granted index + 1) mod P_NUM_REQ. With no grant, rr_ptr SHALL hold.

REQ-009 Single valid request: that request SHALL be granted on port A, with wrb_valid_o = 0 the next cycle.

REQ-010 All requesters valid with distinct addresses: two requesters SHALL be granted per cycle, and every requester SHALL be granted within ceil(P_NUM_REQ/2) cycles (no starvation).

REQ-011 A requester that drops valid without receiving ready SHALL lose nothing; there is no internal buffering beyond the output register.

Reset
REQ-012 While rst_i = 1, asynchronously:
- rr_ptr = 0;
- wra_valid_o = wrb_valid_o = 0;
- wr*_addr_o = 0 and wr*_data_o = 0;
- req_ready_o = 0;
- stall_cnt_o = 0.

REQ-013 Reset asserted mid-operation SHALL discard registered-but-pending writes: valids clear immediately, with no RAM write on the following edge.

REQ-014 After rst_i deasserts, the first grant SHALL be possible in the first clk_i cycle.

Configuration
REQ-015 With macro MPRAM_WR_ARB_STATS_EN defined, stall_cnt_o SHALL:
- increment by 1 each cycle in which at least one valid requester is not granted;
- saturate at 32'hFFFF_FFFF.

REQ-016 Without MPRAM_WR_ARB_STATS_EN, stall_cnt_o SHALL be constant 0, and no counter flops SHALL be synthesized.

Structure
REQ-017 Package mpram_pkg SHALL hold:
- a parameterized typedef mpram_wr_req_t {addr, data, valid};
- the default constants MPRAM_DEPTH = 2048 and MPRAM_WIDTH = 32.

REQ-018 Sub-module mpram_rr_picker SHALL return a one-hot first-set index at or after a start pointer, given a candidate mask. The arbiter SHALL instantiate it twice: for G0, and for G1 with G0 and same-address candidates masked off.

Verification
(P_NUM_REQ = 4, default depth and width.)

REQ-019 Idle after reset: no valids for 10 cycles -> all outputs 0, rr_ptr = 0, stall_cnt_o = 0.

REQ-020 Two requests with distinct addresses: req0 (addr 0x010, data 0xA5A5A5A5) and req2 (addr 0x020, data 0x5A5A5A5A) valid -> both ready that cycle. Next cycle: wra = {0x010, 0xA5A5A5A5, 1}, wrb = {0x020, 0x5A5A5A5A, 1}, and rr_ptr = 3.

REQ-021 Same-address conflict: req1 and req3 both at addr 0x100 with rr_ptr = 0 -> only req1 ready. Next cycle: wra = req1, wrb_valid_o = 0, and req3 is granted the following cycle.

REQ-022 Fairness: all 4 requesters held valid with distinct addresses for 8 cycles -> grant pairs {0,1}, {2,3}, {0,1}, ..., with each requester granted 4 times.

REQ-023 Reset mid-stream: rst_i asserted the cycle after grant of addr 0x7FF -> wra_valid_o drops to 0 asynchronously, and no write is issued to 0x7FF.

REQ-024 With MPRAM_WR_ARB_STATS_EN: 3 requesters valid for 5 cycles -> stall_cnt_o = 5 afterwards. Without the macro: stall_cnt_o = 0.
